// File: rtl/lfsr_range_fifo.sv
// Galois LFSR feeding a small FIFO with uniformly distributed values in MIN..MAX.
// Out-of-range candidates are rejected rather than clamped.
module lfsr_range_fifo #(
  parameter int unsigned    N     = 16,
  parameter logic [N-1:0]   TAPS  = 16'hB400,
  parameter int unsigned    MIN   = 1,
  parameter int unsigned    MAX   = 10,
  parameter int unsigned    OW    = 4,
  parameter int unsigned    DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_ena,
  input  logic                     i_seed_load,
  input  logic [N-1:0]             i_seed,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [OW-1:0]            o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned Range = MAX - MIN + 1;
  localparam int unsigned RBits = (Range > 1) ? $clog2(Range) : 1;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;

  localparam logic [RBits:0]  RangeL = Range[RBits:0];
  localparam logic [OW-1:0]   MinL   = MIN[OW-1:0];
  localparam logic [CW-1:0]   DepthL = DEPTH[CW-1:0];

  logic [N-1:0]    state_q, state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [OW-1:0]   mem_q [DEPTH];

  logic [RBits-1:0] cand;
  logic             accept;
  logic             pop;
  logic             step;
  logic             push;

  assign cand   = state_q[RBits-1:0];
  assign accept = {1'b0, cand} < RangeL;
  assign pop    = o_valid & i_ready;
  // A full FIFO may still step when the head is leaving this cycle.
  assign step   = i_ena & ~i_seed_load & ((count_q != DepthL) | pop);
  assign push   = step & accept;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_seed_load) begin
      state_d  = (i_seed == '0) ? N'(1) : i_seed;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (step) begin
        // An all-zero state would lock up the shifter, so restart from 1.
        if (state_q == '0) begin
          state_d = N'(1);
        end else begin
          state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= N'(1);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= MinL + OW'(cand);
    end
  end

  assign o_valid = (count_q != '0);
  assign o_data  = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_count = count_q;

endmodule

// File: doc/lfsr_range_fifo.md
LFSR_RANGE_FIFO -- requirements
Module: lfsr_range_fifo

Interface
REQ-001 The block SHALL take parameter N, default 16, as the LFSR state width (N >= 4).
REQ-002 The block SHALL take parameter TAPS, default 16'hB400, as the Galois feedback mask (N bits).
REQ-003 The block SHALL take parameter MIN, default 1, as the lowest output value.
REQ-004 The block SHALL take parameter MAX, default 10, as the highest output value (MAX >= MIN).
REQ-005 The block SHALL take parameter OW, default 4, as the output width (2^OW > MAX).
REQ-006 The block SHALL take parameter DEPTH, default 4, as the output FIFO depth (power of two, >= 2).
REQ-007 The block SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port i_rstn, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have port i_ena, input, 1 bit: generator advance enable.
REQ-010 The block SHALL have port i_seed_load, input, 1 bit: load i_seed and flush the FIFO.
REQ-011 The block SHALL have port i_seed, input, N bits: seed value.
REQ-012 The block SHALL have port i_ready, input, 1 bit: consumer ready.
REQ-013 The block SHALL have port o_valid, output, 1 bit: FIFO non-empty.
REQ-014 The block SHALL have port o_data, output, OW bits: FIFO head value, in range MIN..MAX.
REQ-015 The block SHALL have port o_count, output, clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-016 The block SHALL derive RANGE = MAX-MIN+1, RBITS = max(1, clog2(RANGE)), and candidate = state[RBITS-1:0], taken from the pre-step state.
REQ-017 An LFSR step SHALL set state <= (state >> 1) ^ (state[0] ? TAPS : 0).
REQ-018 A step SHALL occur in a cycle iff i_ena=1, i_seed_load=0, and (o_count < DEPTH or pop=1); otherwise state SHALL hold.
REQ-019 On a step, if candidate < RANGE, MIN+candidate SHALL be pushed; otherwise the candidate SHALL be rejected, with no push.
REQ-020 Clamping SHALL NOT be used; rejection keeps the distribution uniform.
REQ-021 Pop SHALL equal o_valid & i_ready; o_data SHALL advance to the next entry on the cycle after a pop.
REQ-022 o_valid SHALL equal (o_count != 0); o_data SHALL be 0 when o_valid=0.
REQ-023 o_data SHALL be held stable while o_valid=1 and i_ready=0.
REQ-024 A pushed value SHALL appear at the head (o_valid=1) one cycle after its step cycle if the FIFO was empty (1-cycle latency).
REQ-025 Simultaneous push and pop SHALL leave o_count unchanged, including when full or when holding one entry.
REQ-026 FIFO read and write pointers SHALL wrap modulo DEPTH; o_count SHALL never exceed DEPTH or underflow.
REQ-027 i_seed_load=1 SHALL take priority over i_ena and pop: state <= (i_seed==0 ? 1 : i_seed), FIFO emptied, o_count <= 0, with no push in that cycle.
REQ-028 If state ever equals 0, the next enabled step SHALL reload 1 instead of shifting (lock-up guard).

Reset
REQ-029 On i_rstn=0, asynchronously: state = 1, FIFO pointers = 0, o_count = 0, o_valid = 0, o_data = 0.
REQ-030 Reset asserted mid-operation SHALL discard all FIFO contents and pending pushes; the first step after release SHALL use state 1.

Verification
REQ-031 Defaults; release reset; i_ena=1, i_ready=0 for 3 cycles -> candidates 1, 0, 0 (states 0x0001, 0xB400, 0x5A00) pushed; head o_data=2; o_count=3.
REQ-032 Seed load with i_seed=0 -> state=0x0001, o_count=0; with i_seed=0x000F, then one step -> candidate 15 rejected, o_count stays 0, state=0xB407.
REQ-033 i_ready=0, i_ena=1 continuously -> o_count saturates at 4, state frozen; one pop cycle -> exactly one step, o_count stays 4.
REQ-034 FIFO full, then i_ready=1, i_ena=0 -> 4 pops on consecutive cycles, values in push order, then o_valid=0, o_data=0.
REQ-035 Assert i_rstn=0 with o_count=3 -> o_valid=0 and o_count=0 immediately, without waiting for a clock edge; after release, the push sequence repeats REQ-031 exactly.
REQ-036 Over 10^5 pops with random i_ready and MIN=1, MAX=10, every o_data SHALL be in 1..10; each value's frequency SHALL lie within 10% +/- 0.5%.
